u712_reg_cycle_arbiter: RTL
===========================

Name: u712_reg_cycle_arbiter

Overview:
- Shares the MC68000-style chipset register cycle engine between two requesters: the CPU local bus and the PCI bridge.
- Breaks 68040 longword accesses into two sequential 16-bit register cycles.
- Drives the engine's request and attribute inputs and follows its REG_CYCLE/REG_TA handshake.
- Returns one ACK or ERR pulse per transaction to the granted requester.

Parameters:
- TO_CYCLES, 4095: CLK40 cycles allowed in BUSY before REG_TA must arrive. 0 disables the timeout.
- TO_WIDTH, 12: width of the timeout counter.

Ports:
- CLK40  in  1  system clock. All logic is rising-edge.
- nRESET  in  1  reset, asynchronous, active-low.
- CPU_REQ, PCI_REQ  in  1 each  transaction request. Held, with its attributes, until ACK or ERR.
- CPU_RnW, PCI_RnW  in  1 each  1 = read.
- CPU_SIZ, PCI_SIZ  in  2 each  68040 size: 00 long, 01 byte, 10 word, 11 line.
- CPU_A, PCI_A  in  2 each  low address bits.
- CPU_GNT, PCI_GNT  out  1 each  owner of the engine. One-hot or both 0.
- CPU_ACK, PCI_ACK  out  1 each  one-cycle completion pulse.
- CPU_ERR, PCI_ERR  out  1 each  one-cycle error pulse.
- nREGSPACE  out  1  engine request, active low.
- RnW, SIZ0, SIZ1  out  1 each  attributes to the engine.
- A  out  2  address to the engine.
- WORD_HI  out  1  1 while the first (upper) word of a longword is in flight. Selects the datapath half.
- LATCH_HI  out  1  one-cycle pulse at REG_TA of the upper word of a longword read.
- REG_CYCLE  in  1  engine busy flag.
- REG_TA  in  1  engine termination pulse.

Behaviour:
- Reset values:
  - nREGSPACE=1, RnW=1; SIZ0, SIZ1 and A = 0.
  - All GNT, ACK, ERR = 0; WORD_HI=0, LATCH_HI=0.
  - State IDLE, LAST=PCI, timeout counter=0.
- Reset mid-operation returns to IDLE immediately. No ACK or ERR is issued for the aborted transaction. The engine shares nRESET.
- Engine inputs are sampled on the rising edge with no additional synchronizer; the engine is same-clock, opposite edge.
- IDLE:
  - Grant when any REQ=1 and REG_CYCLE=0.
  - If both request, grant the requester other than LAST (round-robin); CPU wins the first contention after reset.
  - Latch the winner's RnW, SIZ and A into internal registers. Set its GNT and update LAST.
  - Line size (11): pulse that requester's ERR for 1 cycle, no engine cycle, stay IDLE with GNT=0. LAST still updates.
  - Long size (00): set WORD_HI=1 and WORDS=2, drive SIZ1=1, SIZ0=0, A=00.
  - Byte or word: WORDS=1; drive the latched SIZ and A unchanged.
  - Next state ISSUE.
- ISSUE:
  - nREGSPACE=0 and attributes stable.
  - On REG_CYCLE=1, set nREGSPACE=1, clear the timeout counter, go BUSY.
  - nREGSPACE must be deasserted before the engine returns to its idle state, so the engine never double-starts.
- BUSY:
  - Wait for REG_TA=1.
  - On REG_TA in the upper word of a long read: LATCH_HI=1 for that cycle.
  - On REG_TA go DRAIN.
  - If TO_CYCLES≠0 and the counter reaches TO_CYCLES: pulse ERR, drop GNT, clear WORD_HI, go DRAIN. The remainder of the longword is abandoned.
  - REG_TA arriving in the same cycle as the timeout: REG_TA wins.
- DRAIN:
  - Wait for REG_CYCLE=0 (engine back to idle).
  - If WORD_HI=1: clear WORD_HI, set A=10, go ISSUE. GNT is held.
  - Otherwise pulse ACK (unless ERR was already issued), clear GNT, go IDLE.
- ACK and ERR:
  - ACK and ERR are mutually exclusive.
  - Exactly one ACK or ERR per granted request.
  - The ACK cycle coincides with the GNT-falling cycle.
- REQ deasserted while granted: ignored. The engine cannot abort, so the sequence completes and ACK still pulses.
- A new request is not granted in the ACK cycle. The earliest new grant is the next IDLE cycle.
- GNT never changes owner between the two halves of a longword.

Test Plan:
- CPU word read, A=10: nREGSPACE low until REG_CYCLE rises; REG_TA → DRAIN; REG_CYCLE falls → CPU_ACK 1 cycle. Expect SIZ1=1, SIZ0=0, A=10 throughout.
- PCI long write, A=00:
  - Expect two engine cycles: A=00 with WORD_HI=1, then A=10 with WORD_HI=0.
  - One PCI_ACK only after the second REG_CYCLE fall.
  - LATCH_HI is never pulsed.
- CPU long read: LATCH_HI pulses exactly once, coincident with the first REG_TA.
- CPU_REQ and PCI_REQ asserted in the same cycle, three times back-to-back: grants are CPU, PCI, CPU. PCI_GNT stays 0 during the CPU longword.
- Timeout with TO_CYCLES=16 and REG_TA withheld: ERR pulses 16 cycles after entering BUSY.
  - Then REG_CYCLE deasserted → IDLE, no ACK.
  - Repeat with REG_TA on cycle 16: ACK, no ERR.
- Line request → ERR next cycle, nREGSPACE never low.
- nRESET pulse during BUSY: all outputs return to reset values asynchronously, and the next CPU request is granted normally.

Source files
------------

// File: rtl/u712_reg_cycle_arbiter.sv
// Arbitrates the chipset register cycle engine between the CPU local bus and the
// PCI bridge, splitting longword accesses into an upper and a lower 16-bit cycle.
module u712_reg_cycle_arbiter #(
  parameter int TO_CYCLES = 4095,
  parameter int TO_WIDTH  = 12
) (
  input  logic       CLK40,
  input  logic       nRESET,
  input  logic       CPU_REQ,
  input  logic       PCI_REQ,
  input  logic       CPU_RnW,
  input  logic       PCI_RnW,
  input  logic [1:0] CPU_SIZ,
  input  logic [1:0] PCI_SIZ,
  input  logic [1:0] CPU_A,
  input  logic [1:0] PCI_A,
  output logic       CPU_GNT,
  output logic       PCI_GNT,
  output logic       CPU_ACK,
  output logic       PCI_ACK,
  output logic       CPU_ERR,
  output logic       PCI_ERR,
  output logic       nREGSPACE,
  output logic       RnW,
  output logic       SIZ0,
  output logic       SIZ1,
  output logic [1:0] A,
  output logic       WORD_HI,
  output logic       LATCH_HI,
  input  logic       REG_CYCLE,
  input  logic       REG_TA
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DRAIN} state_t;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'((TO_CYCLES == 0) ? 0 : TO_CYCLES - 1);

  state_t              state, state_nx;
  logic                last_pci, last_pci_nx;
  logic                rnw_q, rnw_nx;
  logic [1:0]          siz_q, siz_nx;
  logic [1:0]          a_q, a_nx;
  logic                word_hi_q, word_hi_nx;
  logic                cpu_gnt_q, cpu_gnt_nx, pci_gnt_q, pci_gnt_nx;
  logic                cpu_ack_q, cpu_ack_nx, pci_ack_q, pci_ack_nx;
  logic                cpu_err_q, cpu_err_nx, pci_err_q, pci_err_nx;
  logic                err_done, err_done_nx;
  logic                nreg_q, nreg_nx;
  logic [TO_WIDTH-1:0] to_cnt, to_cnt_nx;

  logic                pick_pci, sel_rnw, pulse_out, to_hit;
  logic [1:0]          sel_siz, sel_a;

  // Round-robin: on contention the side that did not win last time goes first.
  assign pick_pci  = PCI_REQ & (~CPU_REQ | ~last_pci);
  assign sel_rnw   = pick_pci ? PCI_RnW : CPU_RnW;
  assign sel_siz   = pick_pci ? PCI_SIZ : CPU_SIZ;
  assign sel_a     = pick_pci ? PCI_A   : CPU_A;
  // The requester still holds REQ during its ACK/ERR cycle; don't re-grant it.
  assign pulse_out = cpu_ack_q | pci_ack_q | cpu_err_q | pci_err_q;
  assign to_hit    = (TO_CYCLES != 0) && (to_cnt == TO_LAST);

  always_comb begin
    state_nx    = state;
    last_pci_nx = last_pci;
    rnw_nx      = rnw_q;
    siz_nx      = siz_q;
    a_nx        = a_q;
    word_hi_nx  = word_hi_q;
    cpu_gnt_nx  = cpu_gnt_q;
    pci_gnt_nx  = pci_gnt_q;
    cpu_ack_nx  = 1'b0;
    pci_ack_nx  = 1'b0;
    cpu_err_nx  = 1'b0;
    pci_err_nx  = 1'b0;
    err_done_nx = err_done;
    to_cnt_nx   = to_cnt;
    case (state)
      IDLE: begin
        if ((CPU_REQ || PCI_REQ) && !REG_CYCLE && !pulse_out) begin
          last_pci_nx = pick_pci;
          err_done_nx = 1'b0;
          if (sel_siz == SIZ_LINE) begin
            cpu_err_nx = ~pick_pci;
            pci_err_nx = pick_pci;
          end else begin
            cpu_gnt_nx = ~pick_pci;
            pci_gnt_nx = pick_pci;
            rnw_nx     = sel_rnw;
            if (sel_siz == SIZ_LONG) begin
              word_hi_nx = 1'b1;
              siz_nx     = SIZ_WORD;
              a_nx       = 2'b00;
            end else begin
              siz_nx     = sel_siz;
              a_nx       = sel_a;
            end
            state_nx = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (REG_CYCLE) begin
          to_cnt_nx = '0;
          state_nx  = BUSY;
        end
      end
      BUSY: begin
        if (REG_TA) begin
          state_nx = DRAIN;
        end else if (to_hit) begin
          cpu_err_nx  = cpu_gnt_q;
          pci_err_nx  = pci_gnt_q;
          cpu_gnt_nx  = 1'b0;
          pci_gnt_nx  = 1'b0;
          word_hi_nx  = 1'b0;
          err_done_nx = 1'b1;
          state_nx    = DRAIN;
        end else begin
          to_cnt_nx = to_cnt + TO_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (!REG_CYCLE) begin
          if (word_hi_q) begin
            word_hi_nx = 1'b0;
            a_nx       = 2'b10;
            state_nx   = ISSUE;
          end else begin
            if (!err_done) begin
              cpu_ack_nx = cpu_gnt_q;
              pci_ack_nx = pci_gnt_q;
            end
            cpu_gnt_nx = 1'b0;
            pci_gnt_nx = 1'b0;
            state_nx   = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Registered from the next state so the request drops on the same edge the
    // engine's busy flag is seen, before the engine can return to idle.
    nreg_nx = (state_nx != ISSUE);
  end

  always_ff @(posedge CLK40 or negedge nRESET) begin
    if (!nRESET) begin
      state     <= IDLE;
      last_pci  <= 1'b1;
      rnw_q     <= 1'b1;
      siz_q     <= 2'b00;
      a_q       <= 2'b00;
      word_hi_q <= 1'b0;
      cpu_gnt_q <= 1'b0;
      pci_gnt_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      pci_ack_q <= 1'b0;
      cpu_err_q <= 1'b0;
      pci_err_q <= 1'b0;
      err_done  <= 1'b0;
      nreg_q    <= 1'b1;
      to_cnt    <= '0;
    end else begin
      state     <= state_nx;
      last_pci  <= last_pci_nx;
      rnw_q     <= rnw_nx;
      siz_q     <= siz_nx;
      a_q       <= a_nx;
      word_hi_q <= word_hi_nx;
      cpu_gnt_q <= cpu_gnt_nx;
      pci_gnt_q <= pci_gnt_nx;
      cpu_ack_q <= cpu_ack_nx;
      pci_ack_q <= pci_ack_nx;
      cpu_err_q <= cpu_err_nx;
      pci_err_q <= pci_err_nx;
      err_done  <= err_done_nx;
      nreg_q    <= nreg_nx;
      to_cnt    <= to_cnt_nx;
    end
  end

  assign CPU_GNT   = cpu_gnt_q;
  assign PCI_GNT   = pci_gnt_q;
  assign CPU_ACK   = cpu_ack_q;
  assign PCI_ACK   = pci_ack_q;
  assign CPU_ERR   = cpu_err_q;
  assign PCI_ERR   = pci_err_q;
  assign nREGSPACE = nreg_q;
  assign RnW       = rnw_q;
  assign SIZ0      = siz_q[0];
  assign SIZ1      = siz_q[1];
  assign A         = a_q;
  assign WORD_HI   = word_hi_q;
  // Upper half of a longword read must be captured while the engine presents it.
  assign LATCH_HI  = (state == BUSY) & REG_TA & word_hi_q & rnw_q;

endmodule
